// File: rtl/sevenseg_scan.sv
// sevenseg_scan -- four-digit seven-segment scanner.
//   Holds a 4-digit BCD shadow frame and shows it one digit at a time. Each digit
//   slot lasts REFRESH_DIV cycles. The first GUARD cycles of a slot keep every anode
//   off so the previous digit does not ghost into the next one.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          1 = scan, 0 = display dark with scan state parked at digit 0
//   value, load     frame to capture, level request; load_ack pulses on capture
//   blank_lz        blank leading zeros on digits 3..1
//   dp_mask         decimal point per digit (bit n = digit n), sampled live
//   digit           BCD code of the active digit (4'hF = blank)
//   an, dp          active-low anodes (one-hot-low when lit), active-low decimal point
module sevenseg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic        load,
    output logic        load_ack,
    input  logic        blank_lz,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST    = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_W = PW'(GUARD);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          en_q;
    logic          lock_q, lock_d;
    logic          ack_q, ack_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    digit_q, digit_d;
    logic          dp_q, dp_d;
    logic          tick;
    logic          lz;
    logic [3:0]    nib;

    assign tick = (presc_q == LAST);

    // Nibble and leading-zero test use the next shadow/idx so the code shown after a
    // boundary capture already comes from the new frame.
    always_comb begin
        nib = shadow_d[4*idx_d +: 4];
        lz  = 1'b0;
        case (idx_d)
            2'd1:    lz = (shadow_d[15:4]  == 12'h0);
            2'd2:    lz = (shadow_d[15:8]  == 8'h0);
            2'd3:    lz = (shadow_d[15:12] == 4'h0);
            default: lz = 1'b0;   // digit 0 is never blanked
        endcase
    end

    always_comb begin
        presc_d  = presc_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        ack_d    = 1'b0;
        an_d     = 4'hF;
        digit_d  = 4'hF;
        dp_d     = 1'b1;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) idx_d = idx_q + 2'd1;
            // Frame boundary: only here may the shadow change, so a frame is never torn.
            if (tick && idx_q == 2'd3 && load) begin
                shadow_d = value;
                ack_d    = 1'b1;
            end
        end else begin
            presc_d = '0;
            idx_d   = 2'd0;
            // The cycle enable falls (en_q still 1) captures nothing, so a drop that
            // lands on a boundary tick neither loads nor acknowledges.
            if (load && !en_q) begin
                shadow_d = value;
                ack_d    = !lock_q;
            end
        end
        if (enable) begin
            digit_d = (blank_lz && lz) ? 4'hF : nib;
            // Outputs are registered from next state, so anodes light only once the
            // slot has moved past its guard cycles.
            if (presc_d >= GUARD_W) begin
                an_d = ~(4'b0001 << idx_d);
                dp_d = ~dp_mask[idx_d];
            end
        end
    end

    // Lock suppresses repeated acks while a disabled-mode request stays high.
    always_comb begin
        lock_d = lock_q;
        if (!load)      lock_d = 1'b0;
        else if (ack_d) lock_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0;
            en_q     <= 1'b0;
            lock_q   <= 1'b0;
            ack_q    <= 1'b0;
            an_q     <= 4'hF;
            digit_q  <= 4'hF;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            en_q     <= enable;
            lock_q   <= lock_d;
            ack_q    <= ack_d;
            an_q     <= an_d;
            digit_q  <= digit_d;
            dp_q     <= dp_d;
        end
    end

    assign load_ack = ack_q;
    assign digit    = digit_q;
    assign an       = an_q;
    assign dp       = dp_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
module tb_sevenseg_scan;
    localparam int DIV = 4;
    localparam int GRD = 1;
    localparam int LIT = DIV - GRD;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] d;
        logic       dp;
        logic       ack;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic        load_ack;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        dp;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    sevenseg_scan #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .load(load),
        .load_ack(load_ack), .blank_lz(blank_lz), .dp_mask(dp_mask),
        .digit(digit), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] a, input logic [3:0] d, input logic p, input logic k);
        exp_t e;
        e.an = a; e.d = d; e.dp = p; e.ack = k;
        sb.push_back(e);
    endtask

    // One digit slot: optional guard cycle (all anodes off, dp off), then LIT lit cycles.
    task automatic push_slot(input int idx, input logic [3:0] d, input logic [3:0] dpm,
                             input bit guard, input logic k);
        logic [3:0] one;
        one = 4'b0001;
        if (guard) push(4'hF, d, 1'b1, k);
        for (int i = 0; i < LIT; i++) push(~(one << idx), d, ~dpm[idx], 1'b0);
    endtask

    // Full frame starting at the digit-0 guard cycle; f holds the expected codes per digit.
    task automatic push_frame(input logic [15:0] f, input logic [3:0] dpm, input logic k);
        for (int i = 0; i < 4; i++) push_slot(i, f[4*i +: 4], dpm, 1'b1, (i == 0) ? k : 1'b0);
    endtask

    task automatic push_dark(input int n);
        for (int i = 0; i < n; i++) push(4'hF, 4'hF, 1'b1, 1'b0);
    endtask

    task automatic run(input int n, input string tag);
        exp_t e;
        exp_t o;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL %s: scoreboard empty, observed an=%b digit=%h", tag, an, digit);
            end else begin
                e = sb.pop_front();
                o.an = an; o.d = digit; o.dp = dp; o.ack = load_ack;
                assert (o === e) else begin
                    errors++;
                    $error("FAIL %s cyc%0d: observed an=%b digit=%h dp=%b ack=%b, expected an=%b digit=%h dp=%b ack=%b",
                           tag, i, o.an, o.d, o.dp, o.ack, e.an, e.d, e.dp, e.ack);
                end
            end
        end
    endtask

    task automatic check_dark(input string tag);
        checks++;
        assert (an === 4'hF && digit === 4'hF && dp === 1'b1 && load_ack === 1'b0) else begin
            errors++;
            $error("FAIL %s: observed an=%b digit=%h dp=%b ack=%b, expected an=1111 digit=f dp=1 ack=0",
                   tag, an, digit, dp, load_ack);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; value = 16'h0; load = 1'b0;
        blank_lz = 1'b0; dp_mask = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_dark("reset_init");
        rst_n = 1'b1;

        // Disabled-mode load: one ack even though load is held two cycles.
        value = 16'h1234; load = 1'b1;
        push(4'hF, 4'hF, 1'b1, 1'b1);
        push(4'hF, 4'hF, 1'b1, 1'b0);
        run(2, "load_dis");
        load = 1'b0;
        push_dark(1);
        run(1, "load_dis_rel");

        // Scan 1234: first slot's guard was the dark cycle before enable.
        enable = 1'b1;
        push_slot(0, 4'h4, 4'h0, 1'b0, 1'b0);
        push_slot(1, 4'h3, 4'h0, 1'b1, 1'b0);
        push_slot(2, 4'h2, 4'h0, 1'b1, 1'b0);
        push_slot(3, 4'h1, 4'h0, 1'b1, 1'b0);
        run(15, "scan_first");

        // Tear-free load requested during idx=1.
        push_frame(16'h1234, 4'h0, 1'b0);
        push_frame(16'h5678, 4'h0, 1'b1);
        run(5, "scan_1234");
        value = 16'h5678; load = 1'b1;
        run(11, "tearfree_hold");
        run(1, "tearfree_ack");
        load = 1'b0;
        run(15, "frame_5678");

        // Decimal point on digit 2 only, live mask.
        dp_mask = 4'b0100;
        push_frame(16'h5678, 4'b0100, 1'b0);
        run(16, "dp_digit2");

        // Leading-zero blanking.
        dp_mask = 4'h0; blank_lz = 1'b1; value = 16'h0040; load = 1'b1;
        push_frame(16'hFF40, 4'h0, 1'b1);
        run(1, "lz_0040_ack");
        load = 1'b0;
        run(15, "lz_0040");
        value = 16'h0000; load = 1'b1;
        push_frame(16'hFFF0, 4'h0, 1'b1);
        run(1, "lz_0000_ack");
        load = 1'b0;
        run(15, "lz_0000");
        blank_lz = 1'b0;
        push_frame(16'h0000, 4'h0, 1'b0);
        run(16, "nolz_0000");

        // Enable drops on the boundary tick with load high: no capture, no ack.
        enable = 1'b0; value = 16'h9999; load = 1'b1;
        push_dark(1);
        run(1, "en_drop");
        load = 1'b0;
        push_dark(2);
        run(2, "en_dark");
        enable = 1'b1;
        push_slot(0, 4'h0, 4'h0, 1'b0, 1'b0);
        push_slot(1, 4'h0, 4'h0, 1'b1, 1'b0);
        push_slot(2, 4'h0, 4'h0, 1'b1, 1'b0);
        push_slot(3, 4'h0, 4'h0, 1'b1, 1'b0);
        run(15, "shadow_kept");

        // Asynchronous reset in the middle of a lit slot.
        value = 16'h4321; load = 1'b0;
        rst_n = 1'b0;
        #1;
        check_dark("reset_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_slot(0, 4'h0, 4'h0, 1'b0, 1'b0);
        push_slot(1, 4'h0, 4'h0, 1'b1, 1'b0);
        run(7, "after_reset");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d leftover entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
